// File: rtl/alu_arbiter.sv
// Two-requester front end for a single 32-bit ALU (ADD/SUB/AND/OR, flags {N,Z,C,V}).
// Round-robin grant, one operation in flight, operands and result registered.
module alu_arbiter #(
  parameter int RSP_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] Req0SrcA,
  input  logic [31:0] Req0SrcB,
  input  logic [1:0]  Req0Ctrl,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] Req1SrcA,
  input  logic [31:0] Req1SrcB,
  input  logic [1:0]  Req1Ctrl,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,

  output logic [31:0] RspResult,
  output logic [3:0]  RspFlag,
  output logic        busy,
  output logic        timeout_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int CNT_W = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT) : 1;

  logic [1:0]  state;
  logic [1:0]  state_next;
  logic        last_grant;
  logic        grant;
  logic        op_id;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [1:0]  op_ctrl;

  logic        accept;
  logic        rsp_hs;
  logic        timeout_hit;

  logic [32:0] alu_wide;
  logic [31:0] alu_result;
  logic        alu_carry;
  logic        alu_ovf;
  logic [3:0]  alu_flag;

  // Tie goes to whichever requester was not served last.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  assign req0_ready = (state == ST_IDLE) && req0_valid && !grant;
  assign req1_ready = (state == ST_IDLE) && req1_valid && grant;
  assign accept     = req0_ready || req1_ready;

  assign rsp0_valid = (state == ST_RESP) && !op_id;
  assign rsp1_valid = (state == ST_RESP) && op_id;
  assign rsp_hs     = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);

  assign busy        = (state != ST_IDLE);
  assign timeout_err = timeout_hit;

  generate
    if (RSP_TIMEOUT > 0) begin : g_timeout
      logic [CNT_W-1:0] rsp_cnt;

      // Counter is cleared while in EXEC so it always starts at zero on RESP entry.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          rsp_cnt <= '0;
        end else if (state == ST_EXEC) begin
          rsp_cnt <= '0;
        end else if ((state == ST_RESP) && !rsp_hs) begin
          rsp_cnt <= rsp_cnt + CNT_W'(1);
        end
      end

      assign timeout_hit = (state == ST_RESP) && !rsp_hs &&
                           (rsp_cnt == CNT_W'(RSP_TIMEOUT - 1));
    end else begin : g_no_timeout
      assign timeout_hit = 1'b0;
    end
  endgenerate

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = ST_EXEC;
      ST_EXEC: state_next = ST_RESP;
      ST_RESP: if (rsp_hs || timeout_hit) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // ALU operates only on the latched operands, never on live requester inputs.
  always_comb begin
    alu_wide   = '0;
    alu_result = '0;
    alu_carry  = 1'b0;
    alu_ovf    = 1'b0;
    case (op_ctrl)
      2'b00: begin
        alu_wide   = {1'b0, op_a} + {1'b0, op_b};
        alu_result = alu_wide[31:0];
        alu_carry  = alu_wide[32];
        alu_ovf    = (~op_a[31] & ~op_b[31] &  alu_result[31]) |
                     ( op_a[31] &  op_b[31] & ~alu_result[31]);
      end
      2'b01: begin
        alu_wide   = {1'b0, op_a} - {1'b0, op_b};
        alu_result = alu_wide[31:0];
        alu_carry  = alu_wide[32];
        alu_ovf    = (~op_a[31] &  op_b[31] &  alu_result[31]) |
                     ( op_a[31] & ~op_b[31] & ~alu_result[31]);
      end
      2'b10:   alu_result = op_a & op_b;
      default: alu_result = op_a | op_b;
    endcase
    alu_flag = {alu_result[31], (alu_result == 32'd0), alu_carry, alu_ovf};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: every state and datapath register is reset so outputs are defined straight out of reset.
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      op_id      <= 1'b0;
      op_a       <= '0;
      op_b       <= '0;
      op_ctrl    <= '0;
      RspResult  <= '0;
      RspFlag    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state <= state_next;
      if (accept) begin
        op_id   <= grant;
        op_a    <= grant ? Req1SrcA : Req0SrcA;
        op_b    <= grant ? Req1SrcB : Req0SrcB;
        op_ctrl <= grant ? Req1Ctrl : Req0Ctrl;
      end
      if (state == ST_EXEC) begin
        RspResult <= alu_result;
        RspFlag   <= alu_flag;
      end
      if ((state == ST_RESP) && (rsp_hs || timeout_hit)) begin
        last_grant <= op_id;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one instance waits forever for responses,
// a second one abandons responses after 4 RESP cycles.
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Instance with no response timeout.
  logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready;
  logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready;
  logic [31:0] Req0SrcA, Req0SrcB, Req1SrcA, Req1SrcB, RspResult;
  logic [1:0]  Req0Ctrl, Req1Ctrl;
  logic [3:0]  RspFlag;
  logic        busy, timeout_err;

  // Instance with RSP_TIMEOUT = 4.
  logic        t_req0_valid, t_req0_ready, t_rsp0_valid, t_rsp0_ready;
  logic        t_req1_valid, t_req1_ready, t_rsp1_valid, t_rsp1_ready;
  logic [31:0] t_Req0SrcA, t_Req0SrcB, t_Req1SrcA, t_Req1SrcB, t_RspResult;
  logic [1:0]  t_Req0Ctrl, t_Req1Ctrl;
  logic [3:0]  t_RspFlag;
  logic        t_busy, t_timeout_err;

  alu_arbiter #(.RSP_TIMEOUT(0)) dut0 (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .Req0SrcA(Req0SrcA), .Req0SrcB(Req0SrcB), .Req0Ctrl(Req0Ctrl),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .Req1SrcA(Req1SrcA), .Req1SrcB(Req1SrcB), .Req1Ctrl(Req1Ctrl),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .RspResult(RspResult), .RspFlag(RspFlag),
    .busy(busy), .timeout_err(timeout_err)
  );

  alu_arbiter #(.RSP_TIMEOUT(4)) dut4 (
    .clk(clk), .reset(reset),
    .req0_valid(t_req0_valid), .req0_ready(t_req0_ready),
    .Req0SrcA(t_Req0SrcA), .Req0SrcB(t_Req0SrcB), .Req0Ctrl(t_Req0Ctrl),
    .rsp0_valid(t_rsp0_valid), .rsp0_ready(t_rsp0_ready),
    .req1_valid(t_req1_valid), .req1_ready(t_req1_ready),
    .Req1SrcA(t_Req1SrcA), .Req1SrcB(t_Req1SrcB), .Req1Ctrl(t_Req1Ctrl),
    .rsp1_valid(t_rsp1_valid), .rsp1_ready(t_rsp1_ready),
    .RspResult(t_RspResult), .RspFlag(t_RspFlag),
    .busy(t_busy), .timeout_err(t_timeout_err)
  );

  task automatic check1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single-requester operation on dut0 with its rsp_ready already high.
  task automatic run_single(input string tag, input logic id,
                            input logic [31:0] a, input logic [31:0] b, input logic [1:0] ctrl,
                            input logic [31:0] exp_r, input logic [3:0] exp_f);
    if (id) begin
      req1_valid = 1'b1; Req1SrcA = a; Req1SrcB = b; Req1Ctrl = ctrl;
    end else begin
      req0_valid = 1'b1; Req0SrcA = a; Req0SrcB = b; Req0Ctrl = ctrl;
    end
    #1;
    check1({tag, "_ready"}, id ? req1_ready : req0_ready, 1'b1);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    check1({tag, "_exec_busy"}, busy, 1'b1);
    step();
    check1({tag, "_rsp_valid"}, id ? rsp1_valid : rsp0_valid, 1'b1);
    check32({tag, "_result"}, RspResult, exp_r);
    check32({tag, "_flags"}, 32'(RspFlag), 32'(exp_f));
    step();
    check1({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    Req0SrcA = 0; Req0SrcB = 0; Req0Ctrl = 0; Req1SrcA = 0; Req1SrcB = 0; Req1Ctrl = 0;
    t_req0_valid = 0; t_req1_valid = 0; t_rsp0_ready = 0; t_rsp1_ready = 0;
    t_Req0SrcA = 0; t_Req0SrcB = 0; t_Req0Ctrl = 0; t_Req1SrcA = 0; t_Req1SrcB = 0; t_Req1Ctrl = 0;

    // Reset values
    #2;
    check1("rst_busy", busy, 1'b0);
    check1("rst_rsp0_valid", rsp0_valid, 1'b0);
    check1("rst_rsp1_valid", rsp1_valid, 1'b0);
    check32("rst_result", RspResult, 32'h0);
    check32("rst_flags", 32'(RspFlag), 32'h0);
    check1("rst_timeout_err", t_timeout_err, 1'b0);
    check1("rst_t_busy", t_busy, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check1("rst_rel_req0_ready", req0_ready, 1'b0);

    // 1: req0 add 0x7FFFFFFF + 1, overflow into sign bit
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    req0_valid = 1'b1; Req0SrcA = 32'h7FFF_FFFF; Req0SrcB = 32'h1; Req0Ctrl = 2'b00;
    #1;
    check1("t1_req0_ready", req0_ready, 1'b1);
    check1("t1_req1_ready", req1_ready, 1'b0);
    step();
    req0_valid = 1'b0;
    #1;
    check1("t1_exec_busy", busy, 1'b1);
    check1("t1_exec_rsp0", rsp0_valid, 1'b0);
    step();
    check1("t1_rsp0_valid", rsp0_valid, 1'b1);
    check1("t1_rsp1_valid", rsp1_valid, 1'b0);
    check32("t1_result", RspResult, 32'h8000_0000);
    check32("t1_flags", 32'(RspFlag), 32'h9);
    step();
    check1("t1_rsp0_drop", rsp0_valid, 1'b0);
    check1("t1_idle", busy, 1'b0);
    check32("t1_result_hold", RspResult, 32'h8000_0000);

    // 2: req1 subtractions, zero result then borrow
    run_single("t2_sub_eq", 1'b1, 32'd5, 32'd5, 2'b01, 32'h0, 4'b0100);
    run_single("t2_sub_lt", 1'b1, 32'd3, 32'd5, 2'b01, 32'hFFFF_FFFE, 4'b1010);

    // 3: both requesters held valid, grants must alternate 0,1,0,1
    req0_valid = 1'b1; Req0SrcA = 32'hF0F0_F0F0; Req0SrcB = 32'hFF00_FF00; Req0Ctrl = 2'b10;
    req1_valid = 1'b1; Req1SrcA = 32'h0000_000F; Req1SrcB = 32'h0000_00F0; Req1Ctrl = 2'b11;
    for (int k = 0; k < 4; k++) begin
      logic id;
      id = k[0];
      #1;
      check1("t3_req0_ready", req0_ready, !id);
      check1("t3_req1_ready", req1_ready, id);
      step();
      check1("t3_exec_no_ready", req0_ready | req1_ready, 1'b0);
      step();
      check1("t3_rsp0_valid", rsp0_valid, !id);
      check1("t3_rsp1_valid", rsp1_valid, id);
      check32("t3_result", RspResult, id ? 32'h0000_00FF : 32'hF000_F000);
      check32("t3_flags", 32'(RspFlag), id ? 32'h0 : 32'h8);
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // 4: response stalled 10 cycles with no timeout; req1 waits
    rsp0_ready = 1'b0;
    req0_valid = 1'b1; Req0SrcA = 32'd1; Req0SrcB = 32'd2; Req0Ctrl = 2'b00;
    req1_valid = 1'b1; Req1SrcA = 32'hFF; Req1SrcB = 32'h0F; Req1Ctrl = 2'b10;
    #1;
    check1("t4_req0_ready", req0_ready, 1'b1);
    check1("t4_req1_ready", req1_ready, 1'b0);
    step();
    req0_valid = 1'b0;
    step();
    for (int i = 0; i < 10; i++) begin
      check1("t4_rsp0_hold", rsp0_valid, 1'b1);
      check32("t4_result_hold", RspResult, 32'd3);
      check1("t4_req1_stalled", req1_ready, 1'b0);
      check1("t4_no_timeout", timeout_err, 1'b0);
      step();
    end
    rsp0_ready = 1'b1;
    step();
    check1("t4_idle", busy, 1'b0);
    check1("t4_rsp0_drop", rsp0_valid, 1'b0);
    check1("t4_req1_granted", req1_ready, 1'b1);
    step();
    req1_valid = 1'b0;
    step();
    check1("t4_rsp1_valid", rsp1_valid, 1'b1);
    check32("t4_req1_result", RspResult, 32'h0F);
    check32("t4_req1_flags", 32'(RspFlag), 32'h0);
    step();

    // 5: RSP_TIMEOUT=4 instance, rsp1_ready never asserted
    t_req1_valid = 1'b1; t_Req1SrcA = 32'd10; t_Req1SrcB = 32'd3; t_Req1Ctrl = 2'b01;
    #1;
    check1("t5_req1_ready", t_req1_ready, 1'b1);
    step();
    t_req1_valid = 1'b0;
    step();
    for (int c = 1; c <= 4; c++) begin
      check1("t5_rsp1_valid", t_rsp1_valid, 1'b1);
      check1("t5_busy", t_busy, 1'b1);
      check1("t5_timeout_err", t_timeout_err, c == 4);
      step();
    end
    check1("t5_busy_drop", t_busy, 1'b0);
    check1("t5_pulse_end", t_timeout_err, 1'b0);
    check1("t5_rsp1_low", t_rsp1_valid, 1'b0);
    check32("t5_result", t_RspResult, 32'd7);
    step();
    check1("t5_rsp1_still_low", t_rsp1_valid, 1'b0);
    t_req0_valid = 1'b1;
    t_req1_valid = 1'b1;
    #1;
    check1("t5_tie_req0", t_req0_ready, 1'b1);
    check1("t5_tie_req1", t_req1_ready, 1'b0);
    t_req0_valid = 1'b0;
    t_req1_valid = 1'b0;
    step();
    check1("t5_withdrawn_idle", t_busy, 1'b0);

    // 6: reset during EXEC; last_grant is 0 beforehand so a lost reset shows in the tie
    run_single("t6_pre_add", 1'b0, 32'hFFFF_FFFF, 32'h1, 2'b00, 32'h0, 4'b0110);
    req0_valid = 1'b1; Req0SrcA = 32'hFFFF_FFFF; Req0SrcB = 32'h1234_5678; Req0Ctrl = 2'b10;
    #1;
    step();
    req0_valid = 1'b0;
    #1;
    check1("t6_in_exec", busy, 1'b1);
    reset = 1'b1;
    #1;
    check1("t6_async_busy", busy, 1'b0);
    check1("t6_async_rsp0", rsp0_valid, 1'b0);
    check32("t6_async_result", RspResult, 32'h0);
    check32("t6_async_flags", 32'(RspFlag), 32'h0);
    step();
    step();
    reset = 1'b0;
    step();
    check1("t6_post_rsp0", rsp0_valid, 1'b0);
    check1("t6_post_rsp1", rsp1_valid, 1'b0);
    step();
    check1("t6_post_rsp0_b", rsp0_valid, 1'b0);
    req0_valid = 1'b1; Req0SrcA = 32'h0; Req0SrcB = 32'h0; Req0Ctrl = 2'b11;
    req1_valid = 1'b1;
    #1;
    check1("t6_tie_req0", req0_ready, 1'b1);
    check1("t6_tie_req1", req1_ready, 1'b0);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
    check1("t6_rsp0_valid", rsp0_valid, 1'b1);
    check32("t6_flags", 32'(RspFlag), 32'h4);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
